inv_sub_bytes_seq: RTL and testbench
====================================

Name: inv_sub_bytes_seq

Overview:
- Sequences the AES inverse SubBytes step over a full 128-bit state using LANES inverse S-box lookup instances, time-multiplexed across the 16 state bytes.
- Sits in the decryption round datapath between InvShiftRows and AddRoundKey.
- Valid/ready handshake on both sides; holds one state block at a time.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Any other value is a fatal elaboration error.
- GROUPS, 16/LANES, derived, not overridable; number of processing cycles per block.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort to IDLE
- in_valid  in  1  input block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- in_data  in  128  state; byte 0 = [127:120], byte 15 = [7:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  128  inverse-substituted state, same byte order
- busy  out  1  high in BUSY or DONE
- blocks_done  out  16  count of completed output transfers, wraps at 0xFFFF

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, blocks_done=0, group counter=0.
- Lookup: each lane uses the FIPS-197 inverse S-box, full 256-entry coverage, no latch inference. The lookup is combinational and the output is registered in the state register. Spot values: 0x63→0x00, 0x7c→0x01, 0x01→0x09, 0x38→0x76, 0x00→0x52, 0x52→0x48, 0x16→0xff.
- FSM:
  - IDLE: in_ready=1. On in_valid: load in_data into the state register, counter=0, go to BUSY.
  - BUSY: in_ready=0. Each cycle, bytes [counter*LANES .. counter*LANES+LANES-1] are replaced by their inverse S-box values and the counter increments. On the cycle that processes group GROUPS-1: counter=0, go to DONE.
  - DONE: out_valid=1 and out_data = state register, both held stable until out_ready. On out_ready: go to IDLE and increment blocks_done by 1.
- Latency: a block accepted at edge k gives out_valid=1 after edge k+GROUPS. For LANES=4 this is 4 cycles; for LANES=16 it is 1 cycle.
- Throughput: at most one block per GROUPS+2 cycles. No input acceptance in DONE, even while out_ready is high.
- Untouched bytes: bytes not yet processed keep their loaded value. Each byte is substituted exactly once per block.
- out_data outside DONE: holds the last register value and is don't-care for the bench. Only out_valid qualifies it.
- flush:
  - Takes priority over all transitions: next state IDLE, counter=0, out_valid=0.
  - blocks_done is not incremented, even if out_ready was high the same cycle.
  - in_data is not accepted in a flush cycle.
- Reset mid-operation: aborts immediately to the reset values. The partial block is lost.
- blocks_done: wraps from 0xFFFF to 0x0000 with no flag.
- Handshake stability: outputs change only on clock edges. in_data is sampled only on the accepting edge.

Test Plan:
- LANES=4, in_data=0x6363...63 (16 bytes): out_data=0x00...00 exactly 4 cycles after acceptance; blocks_done=1 after out_ready.
- in_data=0x7c0138005216637c0138005216637c01: out_data=0x0109765248ff00010976524 8ff000109 (byte-wise 0x7c→01, 01→09, 38→76, 00→52, 52→48, 16→ff, 63→00). Repeat for LANES=1 with 16-cycle latency and LANES=16 with 1-cycle latency.
- Exhaustive sweep: 16 blocks covering all 256 byte values, compared against a golden inverse-table model for every lane position. Then run S-box(InvS(x))==x for all x.
- Backpressure: out_ready held low for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored. out_ready=1 -> IDLE next cycle, the next block is accepted the cycle after.
- flush asserted in the 2nd BUSY cycle -> IDLE next edge, out_valid never rises, blocks_done unchanged. A following block processes correctly from counter 0.
- rst_n pulsed low asynchronously mid-BUSY -> outputs go to reset values without a clock edge. Separately, preload blocks_done near 0xFFFF via 65536 transfers (or a force) -> it wraps to 0x0000.

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Inverse AES SubBytes over a 128-bit state, LANES bytes substituted per cycle.
// Latency: 16/LANES cycles from the accepting edge to out_valid.
// Backpressure: one block in flight; in_ready stays low until out_ready takes the result.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [15:0]  blocks_done
);
    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    // Only power-of-two lane counts tile the 16 state bytes evenly.
    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $fatal(1, "inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 inverse S-box, element 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Byte 0 of the state is data_q[0], i.e. bits [127:120].
    logic [0:15][7:0]  data_q, data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic [15:0]       blocks_done_q, blocks_done_d;
    logic [3:0]        base;

    // Next-state logic: load, substitute one lane group per cycle, hold result, flush override.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        blocks_done_d = blocks_done_q;
        base          = 4'(32'(cnt_q) * LANES);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[base + 4'(l)] = INV_SBOX[data_q[base + 4'(l)]];
                end
                if (cnt_q == CW'(GROUPS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d       = IDLE;
                    blocks_done_d = blocks_done_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over every transition: no load, no completion count.
        if (flush) begin
            state_d       = IDLE;
            cnt_d         = '0;
            data_d        = data_q;
            blocks_done_d = blocks_done_q;
        end

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = data_q;
    assign busy        = busy_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: LANES=4 main instance plus LANES=1 and LANES=16 sharing inputs.
// Expected data comes from an inverse table derived from GF(2^8) inversion and the AES affine map.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_inv_sub_bytes_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_data4;
    logic [15:0]  blocks_done4;
    logic         in_ready1, out_valid1, busy1;
    logic [127:0] out_data1;
    logic [15:0]  blocks_done1;
    logic         in_ready16, out_valid16, busy16;
    logic [127:0] out_data16;
    logic [15:0]  blocks_done16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_sbox [256];
    logic [7:0] inv_tab  [256];
    logic [7:0] dut_inv  [256];
    logic [7:0] spot_in  [7] = '{8'h63, 8'h7c, 8'h01, 8'h38, 8'h00, 8'h52, 8'h16};
    logic [7:0] spot_out [7] = '{8'h00, 8'h01, 8'h09, 8'h76, 8'h52, 8'h48, 8'hff};

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .busy(busy4), .blocks_done(blocks_done4));
    inv_sub_bytes_seq #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1), .blocks_done(blocks_done1));
    inv_sub_bytes_seq #(.LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .busy(busy16), .blocks_done(blocks_done16));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] xi, s;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
            fwd_sbox[x] = s;
            inv_tab[s]  = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[d[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block until the LANES=4 instance accepts it.
    task automatic send(input logic [127:0] d, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50; c++) begin
            if (in_ready4) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid4 rises.
    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            tick();
            lat++;
        end
        ok = out_valid4;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 ||
            out_data4 !== 128'h0 || blocks_done4 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_data=%h blocks_done=%h, want 1 0 0 0 0",
                     in_ready4, out_valid4, busy4, out_data4, blocks_done4);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: in_ready=%b busy=%b, want 1 0", in_ready4, busy4);
        end
    endtask

    task automatic test_basic_63();
        bit ok; int lat; logic [15:0] bd0;
        bd0 = blocks_done4;
        send({16{8'h63}}, ok);
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || lat != 4) begin
            n_fail++; $display("FAIL basic63_latency: got %0d (valid=%b) want 4", lat, ok);
        end
        n_checks++;
        if (out_data4 !== 128'h0) begin
            n_fail++; $display("FAIL basic63_data: got %h want 0", out_data4);
        end
        n_checks++;
        if (in_ready4 !== 1'b0 || busy4 !== 1'b1) begin
            n_fail++; $display("FAIL basic63_done_flags: in_ready=%b busy=%b want 0 1", in_ready4, busy4);
        end
        take();
        n_checks++;
        if (blocks_done4 !== bd0 + 16'd1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic63_complete: blocks_done=%h out_valid=%b busy=%b want %h 0 0",
                     blocks_done4, out_valid4, busy4, bd0 + 16'd1);
        end
    endtask

    task automatic test_lanes();
        logic [127:0] pat, exp_pat, d1, d4, d16;
        int l1, l4, l16;
        pat     = 128'h7c0138005216637c0138005216637c01;
        exp_pat = 128'h0109765248ff000109765248ff000109;
        l1 = 0; l4 = 0; l16 = 0; d1 = '0; d4 = '0; d16 = '0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = pat;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid1  && l1  == 0) begin l1  = c; d1  = out_data1;  end
            if (out_valid4  && l4  == 0) begin l4  = c; d4  = out_data4;  end
            if (out_valid16 && l16 == 0) begin l16 = c; d16 = out_data16; end
        end
        n_checks++;
        if (l1 != 16 || l4 != 4 || l16 != 1) begin
            n_fail++; $display("FAIL lanes_latency: got L1=%0d L4=%0d L16=%0d want 16 4 1", l1, l4, l16);
        end
        n_checks++;
        if (d1 !== exp_pat || d4 !== exp_pat || d16 !== exp_pat) begin
            n_fail++; $display("FAIL lanes_data: got %h %h %h want %h", d1, d4, d16, exp_pat);
        end
        n_checks++;
        if (model_inv(pat) !== exp_pat) begin
            n_fail++; $display("FAIL model_pattern: got %h want %h", model_inv(pat), exp_pat);
        end
        take();
        n_checks++;
        if (blocks_done1 !== 16'd1 || blocks_done4 !== 16'd1 || blocks_done16 !== 16'd1) begin
            n_fail++;
            $display("FAIL lanes_blocks_done: got %h %h %h want 1 1 1", blocks_done1, blocks_done4, blocks_done16);
        end
    endtask

    task automatic test_sweep();
        bit ok; int lat; logic [127:0] d, e;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'((((b + i) % 16) * 16) + i);
            e = model_inv(d);
            send(d, ok);
            wait_valid(lat, ok);
            n_checks++;
            if (!ok || out_data4 !== e) begin
                n_fail++; $display("FAIL sweep_block%0d: got %h want %h", b, out_data4, e);
            end
            for (int i = 0; i < 16; i++) dut_inv[d[127-8*i -: 8]] = out_data4[127-8*i -: 8];
            take();
        end
        for (int x = 0; x < 256; x++) begin
            n_checks++;
            if (fwd_sbox[dut_inv[x]] !== 8'(x)) begin
                n_fail++; $display("FAIL sbox_roundtrip: S(InvS(%h))=%h want %h", x[7:0], fwd_sbox[dut_inv[x]], x[7:0]);
            end
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (dut_inv[spot_in[k]] !== spot_out[k]) begin
                n_fail++; $display("FAIL spot_value %h: got %h want %h", spot_in[k], dut_inv[spot_in[k]], spot_out[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [127:0] d, e, nxt;
        d = rand128(); e = model_inv(d); nxt = rand128();
        send(d, ok);
        wait_valid(lat, ok);
        in_valid = 1'b1; in_data = nxt; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (out_valid4 !== 1'b1 || out_data4 !== e || in_ready4 !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: valid=%b ready=%b data=%h want 1 0 %h",
                         c, out_valid4, in_ready4, out_data4, e);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_release: valid=%b ready=%b want 0 1", out_valid4, in_ready4);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_next_accept: busy=%b ready=%b want 1 0", busy4, in_ready4);
        end
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || lat != 4 || out_data4 !== model_inv(nxt)) begin
            n_fail++; $display("FAIL backpressure_next_block: lat=%0d data=%h want 4 %h", lat, out_data4, model_inv(nxt));
        end
        take();
    endtask

    task automatic test_flush();
        bit ok, rose; int lat; logic [127:0] d; logic [15:0] bd0;
        bd0 = blocks_done4;
        send(rand128(), ok);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (in_ready4 !== 1'b1 || busy4 !== 1'b0 || out_valid4 !== 1'b0) begin
            n_fail++; $display("FAIL flush_to_idle: ready=%b busy=%b valid=%b want 1 0 0", in_ready4, busy4, out_valid4);
        end
        rose = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid4) rose = 1'b1;
        end
        n_checks++;
        if (rose || blocks_done4 !== bd0) begin
            n_fail++; $display("FAIL flush_quiet: valid_rose=%b blocks_done=%h want 0 %h", rose, blocks_done4, bd0);
        end
        d = rand128();
        send(d, ok);
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || lat != 4 || out_data4 !== model_inv(d)) begin
            n_fail++; $display("FAIL flush_next_block: lat=%0d data=%h want 4 %h", lat, out_data4, model_inv(d));
        end
        take();
        bd0 = blocks_done4;
        send(rand128(), ok);
        wait_valid(lat, ok);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = rand128();
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || blocks_done4 !== bd0) begin
            n_fail++;
            $display("FAIL flush_in_done: valid=%b busy=%b blocks_done=%h want 0 0 %h", out_valid4, busy4, blocks_done4, bd0);
        end
    endtask

    task automatic test_async_reset();
        bit ok; int lat; logic [127:0] d;
        send(rand128(), ok);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 ||
            out_data4 !== 128'h0 || blocks_done4 !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b valid=%b busy=%b data=%h done=%h want 1 0 0 0 0",
                     in_ready4, out_valid4, busy4, out_data4, blocks_done4);
        end
        #1 rst_n = 1'b1;
        tick();
        d = rand128();
        send(d, ok);
        wait_valid(lat, ok);
        n_checks++;
        if (!ok || lat != 4 || out_data4 !== model_inv(d)) begin
            n_fail++; $display("FAIL after_reset_block: lat=%0d data=%h want 4 %h", lat, out_data4, model_inv(d));
        end
        take();
    endtask

    task automatic test_wrap();
        bit ok; int lat;
        force dut4.blocks_done_q = 16'hfffe;
        #1 release dut4.blocks_done_q;
        tick();
        n_checks++;
        if (blocks_done4 !== 16'hfffe) begin
            n_fail++; $display("FAIL wrap_preload: got %h want fffe", blocks_done4);
        end
        send(rand128(), ok); wait_valid(lat, ok); take();
        n_checks++;
        if (blocks_done4 !== 16'hffff) begin
            n_fail++; $display("FAIL wrap_ffff: got %h want ffff", blocks_done4);
        end
        send(rand128(), ok); wait_valid(lat, ok); take();
        n_checks++;
        if (blocks_done4 !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero: got %h want 0000", blocks_done4);
        end
    endtask

    task automatic test_random();
        bit ok; int lat; logic [127:0] d; logic [15:0] bd0;
        for (int n = 0; n < 24; n++) begin
            bd0 = blocks_done4;
            repeat ($urandom_range(0, 2)) tick();
            d = rand128();
            send(d, ok);
            wait_valid(lat, ok);
            n_checks++;
            if (!ok || lat != 4 || out_data4 !== model_inv(d)) begin
                n_fail++; $display("FAIL random_block%0d: lat=%0d data=%h want 4 %h", n, lat, out_data4, model_inv(d));
            end
            repeat ($urandom_range(0, 3)) tick();
            take();
            n_checks++;
            if (blocks_done4 !== bd0 + 16'd1) begin
                n_fail++; $display("FAIL random_count%0d: got %h want %h", n, blocks_done4, bd0 + 16'd1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_basic_63();
        test_lanes();
        test_sweep();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
